abc_ndist: RTL and testbench

//  N-channel successor to the two-converter distance classifier. Drives N ADC-style

---
 rtl/abc_ndist_pkg.sv | 15 +
 rtl/abc_ndist_if.sv | 18 +
 rtl/abc_ndist_sq_acc.sv | 51 +++++
 rtl/abc_ndist.sv | 116 +++++++++++
 tb/tb_abc_ndist.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/abc_ndist_pkg.sv
// Shared types and helpers for the N-channel distance classifier.
package abc_ndist_pkg;

   // Acquisition side: drive converters, square-and-sum, hand off to buffer
   typedef enum logic [1:0] {S_SOC, S_EOC, S_MAC, S_PUSH} aq_state_t;

   // Output side: dav_/rfd four-phase handshake with the consumer
   typedef enum logic [1:0] {O_IDLE, O_DAV, O_ACK} oq_state_t;

   // Width of the sum of squares. $clog2(1) = 0, so one channel gives exactly 2*W.
   function automatic int dist_width(input int n, input int w);
      return 2 * w + $clog2(n);
   endfunction

endpackage

// File: rtl/abc_ndist_if.sv
// Converter (soc/eoc/x) and consumer (dav_/rfd/z/d) signal bundle.
interface abc_ndist_if import abc_ndist_pkg::*; #(
   parameter int N = 2,
   parameter int W = 8
) ();
   localparam int DW = dist_width(N, W);

   logic [N-1:0]   soc;
   logic [N-1:0]   eoc;
   logic [N*W-1:0] x;
   logic           dav_;
   logic           rfd;
   logic           z;
   logic [DW-1:0]  d;

   modport master (output soc, dav_, z, d, input eoc, x, rfd);
   modport slave  (input soc, dav_, z, d, output eoc, x, rfd);
endinterface

// File: rtl/abc_ndist_sq_acc.sv
// Coordinate bank plus one squarer/adder; sums x_i^2 one channel per cycle.
module sq_acc import abc_ndist_pkg::*; #(
   parameter  int W  = 8,
   parameter  int N  = 2,
   localparam int DW = dist_width(N, W)
) (
   input  logic           clock,
   input  logic           reset_,
   input  logic           start,
   input  logic [N*W-1:0] x,
   output logic           done,
   output logic [DW-1:0]  acc
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic signed [W-1:0]   coord [N];
   logic        [IW-1:0]  idx;
   logic                  busy;
   logic signed [2*W-1:0] sq;

   // Capture every channel's coordinate on the start edge
   // NOTE: the bank has no reset; start always loads it before busy can read it.
   always_ff @(posedge clock) begin
      if (start) begin
         for (int i = 0; i < N; i++) coord[i] <= x[i*W +: W];
      end
   end

   // Signed square at 2*W bits is exact, including (-2^(W-1))^2
   assign sq   = (2*W)'(coord[idx]) * (2*W)'(coord[idx]);
   assign done = busy && (idx == IW'(N - 1));

   // Sequencer: clear on start, add one square per busy cycle, stop after channel N-1
   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         busy <= 1'b0;
         idx  <= '0;
         acc  <= '0;
      end else if (start) begin
         busy <= 1'b1;
         idx  <= '0;
         acc  <= '0;
      end else if (busy) begin
         acc <= acc + DW'(unsigned'(sq));
         idx <= idx + IW'(1);
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/abc_ndist.sv
// N-channel distance classifier: acquisition FSM, one-entry result buffer, output FSM.
module abc_ndist import abc_ndist_pkg::*; #(
   parameter int              N  = 2,
   parameter int              W  = 8,
   parameter longint unsigned R2 = 4096
) (
   input  logic         clock,
   input  logic         reset_,
   abc_ndist_if.master  bus
);
   localparam int DW = dist_width(N, W);
   // A threshold at or beyond 2^DW covers every reachable D, so clamp to all-ones
   localparam logic [DW-1:0] R2_C = (R2 >= (64'd1 << DW)) ? '1 : R2[DW-1:0];

   aq_state_t     aq_q, aq_d;
   oq_state_t     oq_q, oq_d;
   logic          soc_q, soc_d;
   logic          mac_start, mac_done;
   logic          buf_wr, buf_rel;
   logic          full_q, z_q;
   logic [DW-1:0] acc, d_q;

   sq_acc #(.W(W), .N(N)) u_sq_acc (
      .clock  (clock),
      .reset_ (reset_),
      .start  (mac_start),
      .x      (bus.x),
      .done   (mac_done),
      .acc    (acc)
   );

   // Acquisition next-state; S_SOC leaves only once soc has actually been seen high
   always_comb begin
      // NOTE: defaults first so no path through the case can infer a latch.
      aq_d      = aq_q;
      soc_d     = 1'b0;
      mac_start = 1'b0;
      buf_wr    = 1'b0;
      unique case (aq_q)
         S_SOC: begin
            soc_d = 1'b1;
            if (soc_q && (bus.eoc == '0)) begin
               soc_d = 1'b0;
               aq_d  = S_EOC;
            end
         end
         S_EOC: begin
            if (bus.eoc == '1) begin
               mac_start = 1'b1;
               aq_d      = S_MAC;
            end
         end
         S_MAC: begin
            if (mac_done) aq_d = S_PUSH;
         end
         S_PUSH: begin
            if (!full_q) begin
               buf_wr = 1'b1;
               aq_d   = S_SOC;
            end
         end
         default: aq_d = S_SOC;
      endcase
   end

   // Output next-state; leaving O_ACK frees the buffer
   always_comb begin
      oq_d    = oq_q;
      buf_rel = 1'b0;
      unique case (oq_q)
         O_IDLE: if (full_q && bus.rfd) oq_d = O_DAV;
         O_DAV:  if (!bus.rfd) oq_d = O_ACK;
         O_ACK: begin
            if (bus.rfd) begin
               buf_rel = 1'b1;
               oq_d    = O_IDLE;
            end
         end
         default: oq_d = O_IDLE;
      endcase
   end

   // State registers; soc is registered so reset drops it at once and release raises it next clock
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         aq_q  <= S_SOC;
         oq_q  <= O_IDLE;
         soc_q <= 1'b0;
      end else begin
         aq_q  <= aq_d;
         oq_q  <= oq_d;
         soc_q <= soc_d;
      end
   end

   // Result buffer; a write is only attempted when empty, so release and write never collide
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         full_q <= 1'b0;
         z_q    <= 1'b0;
         d_q    <= '0;
      end else if (buf_rel) begin
         full_q <= 1'b0;
      end else if (buf_wr) begin
         full_q <= 1'b1;
         z_q    <= (acc <= R2_C);
         d_q    <= acc;
      end
   end

   assign bus.soc  = {N{soc_q}};
   assign bus.dav_ = (oq_q != O_DAV);
   assign bus.z    = z_q;
   assign bus.d    = d_q;

endmodule

// File: tb/tb_abc_ndist.sv
// Directed bench for abc_ndist at N=2 and N=3 with a scoreboard of expected {z,d}.
module tb_abc_ndist;
   import abc_ndist_pkg::*;

   localparam int W   = 8;
   localparam int LIM = 500;

   logic        clock  = 1'b0;
   logic        reset_ = 1'b0;
   int          n_pass  = 0;
   int          n_total = 0;
   logic [32:0] sb2 [$];
   logic [32:0] sb3 [$];

   always #5 clock = ~clock;

   abc_ndist_if #(.N(2), .W(W)) if2 ();
   abc_ndist_if #(.N(3), .W(W)) if3 ();

   abc_ndist #(.N(2), .W(W), .R2(4096)) dut2 (.clock(clock), .reset_(reset_), .bus(if2.master));
   abc_ndist #(.N(3), .W(W), .R2(4096)) dut3 (.clock(clock), .reset_(reset_), .bus(if3.master));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Independent model: {z, D} with D = sum of squares, z = D <= 4096
   function automatic logic [32:0] expect_of(input int a, input int b, input int c);
      int s;
      s = a * a + b * b + c * c;
      return {(s <= 4096), s};
   endfunction

   task automatic produce2(input int a, input int b, input int drop0, input int drop1);
      int t = 0;
      while (if2.soc !== 2'b11 && t < LIM) begin @(negedge clock); t++; end
      check("soc2_rise", if2.soc, 2'b11);
      for (int c = 1; c <= ((drop0 > drop1) ? drop0 : drop1); c++) begin
         @(negedge clock);
         if (c == drop0) if2.eoc[0] = 1'b0;
         if (c == drop1) if2.eoc[1] = 1'b0;
      end
      check("soc2_held_to_last_eoc", if2.soc, 2'b11);
      t = 0;
      while (if2.soc !== 2'b00 && t < LIM) begin @(negedge clock); t++; end
      check("soc2_fall", if2.soc, 2'b00);
      @(negedge clock);
      if2.x   = {8'(b), 8'(a)};
      if2.eoc = 2'b11;
      sb2.push_back(expect_of(a, b, 0));
   endtask

   task automatic consume2(input int hold, input bit watch);
      logic [32:0] e;
      int t = 0;
      while (if2.dav_ !== 1'b0 && t < LIM) begin @(negedge clock); t++; end
      check("dav2_fall", if2.dav_, 1'b0);
      if (sb2.size() > 0) e = sb2.pop_front();
      else e = 'x;
      check("z2", if2.z, e[32]);
      check("d2", if2.d, e[31:0]);
      @(negedge clock);
      if2.rfd = 1'b0;
      repeat (hold + 1) @(negedge clock);
      if (watch) begin
         check("soc2_stalled", if2.soc, 2'b00);
         check("dav2_ack", if2.dav_, 1'b1);
         check("z2_stable", if2.z, e[32]);
         check("d2_stable", if2.d, e[31:0]);
      end
      if2.rfd = 1'b1;
   endtask

   task automatic produce3(input int a, input int b, input int c);
      int t = 0;
      while (if3.soc !== 3'b111 && t < LIM) begin @(negedge clock); t++; end
      check("soc3_rise", if3.soc, 3'b111);
      @(negedge clock);
      if3.eoc = 3'b000;
      t = 0;
      while (if3.soc !== 3'b000 && t < LIM) begin @(negedge clock); t++; end
      check("soc3_fall", if3.soc, 3'b000);
      @(negedge clock);
      if3.x   = {8'(c), 8'(b), 8'(a)};
      if3.eoc = 3'b111;
      sb3.push_back(expect_of(a, b, c));
   endtask

   task automatic consume3();
      logic [32:0] e;
      int t = 0;
      while (if3.dav_ !== 1'b0 && t < LIM) begin @(negedge clock); t++; end
      check("dav3_fall", if3.dav_, 1'b0);
      if (sb3.size() > 0) e = sb3.pop_front();
      else e = 'x;
      check("z3", if3.z, e[32]);
      check("d3", if3.d, e[31:0]);
      @(negedge clock);
      if3.rfd = 1'b0;
      @(negedge clock);
      if3.rfd = 1'b1;
   endtask

   initial begin
      int lat;
      if2.eoc = '1; if2.x = '0; if2.rfd = 1'b1;
      if3.eoc = '1; if3.x = '0; if3.rfd = 1'b1;

      // Reset values
      #2;
      check("rst_soc2", if2.soc, 2'b00);
      check("rst_dav2", if2.dav_, 1'b1);
      check("rst_z2", if2.z, 1'b0);
      check("rst_d2", if2.d, 0);
      check("rst_soc3", if3.soc, 3'b000);
      check("rst_dav3", if3.dav_, 1'b1);
      repeat (2) @(negedge clock);
      reset_ = 1'b1;
      @(negedge clock);
      check("soc2_first_clock", if2.soc, 2'b11);
      check("soc3_first_clock", if3.soc, 3'b111);

      // N=2: skewed eoc on first sample, then latency eoc all-1 -> dav_ low
      produce2(40, 40, 1, 4);
      lat = 0;
      do begin @(negedge clock); lat++; end while (if2.dav_ !== 1'b0 && lat < LIM);
      check("latency2", lat, 5);
      consume2(0, 1'b0);
      produce2(50, 40, 2, 1);     consume2(1, 1'b0);
      produce2(64, 0, 1, 1);      consume2(0, 1'b0);
      produce2(-128, -128, 3, 2); consume2(2, 1'b0);

      // N=3
      produce3(0, 0, 64);
      lat = 0;
      do begin @(negedge clock); lat++; end while (if3.dav_ !== 1'b0 && lat < LIM);
      check("latency3", lat, 6);
      consume3();
      produce3(37, 37, 37); consume3();

      // Overlapped stream with one slow consumer hold of 40 clocks
      fork
         begin
            for (int k = 0; k < 32; k++)
               produce2(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                        int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
         end
         begin
            for (int k = 0; k < 32; k++)
               consume2((k == 5) ? 40 : int'($urandom_range(0, 3)), k == 5);
         end
      join
      check("sb2_drained", sb2.size(), 0);

      // Reset during S_MAC: pending result discarded
      produce2(10, 20, 1, 1);
      @(posedge clock); #1;
      reset_ = 1'b0;
      #1;
      check("rst_mac_soc2", if2.soc, 2'b00);
      check("rst_mac_soc3", if3.soc, 3'b000);
      check("rst_mac_dav2", if2.dav_, 1'b1);
      check("rst_mac_d2", if2.d, 0);
      sb2.delete();
      @(negedge clock);
      reset_ = 1'b1;
      @(negedge clock);
      check("rst_mac_soc2_rise", if2.soc, 2'b11);
      repeat (10) @(negedge clock);
      check("rst_mac_result_lost", if2.dav_, 1'b1);

      // Reset during O_DAV with soc high
      produce2(60, 10, 2, 2);
      lat = 0;
      while (if2.dav_ !== 1'b0 && lat < LIM) begin @(negedge clock); lat++; end
      check("odav_dav2", if2.dav_, 1'b0);
      check("odav_d2", if2.d, 3700);
      check("odav_soc2", if2.soc, 2'b11);
      #2;
      reset_ = 1'b0;
      #1;
      check("rst_dav_soc2", if2.soc, 2'b00);
      check("rst_dav_dav2", if2.dav_, 1'b1);
      check("rst_dav_z2", if2.z, 1'b0);
      check("rst_dav_d2", if2.d, 0);
      sb2.delete();
      @(negedge clock);
      reset_ = 1'b1;
      @(negedge clock);
      check("rst_dav_soc2_rise", if2.soc, 2'b11);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
